// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder / imem loader.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_I      = 3'd1,
        KIND_LOAD   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_BRANCH = 3'd4,
        KIND_LUI    = 3'd5,
        KIND_JAL    = 3'd6,
        KIND_JALR   = 3'd7
    } op_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded instruction words; head word is presented
// combinationally on pop_data and stays put until popped.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder that buffers packed words and writes them to imem.
// Define ENC_CHECK_EN to range-check immediates (bad ones become NOP and set err).
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    function automatic logic [31:0] encode(
        input op_kind_t    kind,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        case (kind)
            KIND_R:      word = {f7, rs2, rs1, f3, rd, OPC_R};
            KIND_I:      word = {imm[11:0], rs1, f3, rd, OPC_I};
            KIND_LOAD:   word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            KIND_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            KIND_LUI:    word = {imm[31:12], rd, OPC_LUI};
            KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default:     word = NOP_WORD;
        endcase
        return word;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;
    logic [31:0] raw_word;

    assign raw_word  = encode(op_kind_t'(req_kind), req_funct3, req_funct7,
                              req_rd, req_rs1, req_rs2, req_imm);
    assign req_ready = (state == RUN) && !fifo_full;
    assign push      = req_valid && req_ready;
    assign imem_we   = !fifo_empty;
    assign pop       = imem_we && imem_ready;
    assign busy      = (state != IDLE);

`ifdef ENC_CHECK_EN
    // An immediate is representable when every bit above the field's sign bit matches it.
    function automatic logic imm_in_range(input op_kind_t kind, input logic [31:0] imm);
        logic ok;
        case (kind)
            KIND_I, KIND_LOAD, KIND_STORE, KIND_JALR:
                ok = (&imm[31:11]) || !(|imm[31:11]);
            KIND_BRANCH: ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            KIND_JAL:    ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            KIND_LUI:    ok = (imm[11:0] == 12'h000);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    logic imm_bad;

    assign imm_bad  = !imm_in_range(op_kind_t'(req_kind), req_imm);
    assign enc_word = imm_bad ? NOP_WORD : raw_word;

    // Sticky until reset: any accepted out-of-range immediate flags the program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (push && imm_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign enc_word = raw_word;
    assign err      = 1'b0;
`endif

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .pop_data  (imem_wdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN waits for the buffer to empty; done fires in the cycle we leave it.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DRAIN;
            DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr  <= '0;
            word_count <= '0;
        end else if ((state == IDLE) && start) begin
            imem_addr  <= base_addr;
            word_count <= '0;
        end else if (pop) begin
            imem_addr <= imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (word_count != '1) word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

endmodule
